connect4_engine: RTL
====================

# connect4_engine

Parametrised Connect-4 game engine: holds the full board, applies gravity drops per column, alternates players, enforces a per-turn time limit, and detects wins and draws. It sits between the column/load inputs (FPGA switches or Arduino link) and the VGA/board renderer. It generalises the fixed 6-slot loader/controller to an arbitrary ROWS×COLS board with full game logic.

## Interface
- ROWS, 6, board height (≥ WIN_LEN)
- COLS, 7, board width (≥ WIN_LEN)
- WIN_LEN, 4, tokens in a line required to win
- CLK_HZ, 50_000_000, clock cycles per second
- TURN_SECS, 10, seconds allowed per turn
- clk  in  1  system clock; one clock domain
- rst  in  1  reset; synchronous, active-high
- column  in  $clog2(COLS)  target column; column 0 is leftmost
- load  in  1  move request; only its rising edge is used
- first_player  in  1  starting player: 0 = FPGA, 1 = Arduino; sampled in reset
- board  out  2*ROWS*COLS  cell (r,c) at bits [2*(r*COLS+c) +: 2]; row 0 is the bottom row
- cur_player  out  1  player to move
- secs_left  out  $clog2(TURN_SECS+1)  equals TURN_SECS − elapsed seconds
- reject  out  1  one-cycle pulse: move refused
- timeout  out  1  one-cycle pulse: turn forfeited
- game_over  out  1  level signal
- winner  out  2  00 none/draw, 01 FPGA, 10 Arduino
- draw  out  1  board full with no winner

## Operation
- Cell codes: 00 empty, 01 FPGA, 10 Arduino. A player's token = {cur_player, ~cur_player}.
- Reset: board all 00; heights all 0; move_count 0; cur_player = first_player; state WAIT; timer 0; secs_left = TURN_SECS; all pulses 0; game_over/winner/draw 0.
- States: WAIT, CHECK0..CHECK3, OVER.
- WAIT, accepted load edge: column < COLS and heights[column] < ROWS. Write token at (heights[column], column), increment heights[column] and move_count, latch the placed position, go to CHECK0.
- WAIT, refused load edge: column ≥ COLS or column full. Pulse reject, stay in WAIT, timer keeps running.
- CHECKd: directions d0 = (0,+1), d1 = (+1,0), d2 = (+1,+1), d3 = (+1,−1).
  - count = 1 + consecutive same-code cells from the placed cell in the +dir and −dir directions.
  - Each side is bounded by the board edges and capped at WIN_LEN−1.
  - count ≥ WIN_LEN: go to OVER with winner = token.
- Exit from CHECK3 with no win:
  - move_count == ROWS*COLS: go to OVER with draw = 1.
  - Otherwise: toggle cur_player, clear the timer, return to WAIT.
- Turn timer:
  - Counts only in WAIT. It is held (not cleared) during CHECK and frozen in OVER.
  - Seconds tick when the cycle counter reaches CLK_HZ−1; the cycle counter then wraps to 0.
  - When elapsed reaches TURN_SECS in WAIT: pulse timeout, toggle cur_player, clear the timer. The board is unchanged.
- OVER: all load edges are ignored (no reject). Only rst leaves OVER.

## Timing
- Load edge detection: a 1-cycle registered delay of load. A load held high produces exactly one request.
- Accepted move, load edge detected at edge t:
  - board updated from edge t.
  - CHECK0..CHECK3 occupy edges t+1..t+4.
  - cur_player toggles and WAIT resumes after edge t+4.
  - A win in CHECKd asserts game_over after edge t+1+d.
- reject and timeout are registered. They are high for exactly the cycle following the deciding edge.
- Simultaneous load edge and timeout in WAIT: timeout wins. The load edge is discarded without a reject.
- rst has priority over every event, including mid-CHECK. Everything returns to reset values on the next edge.

## Structure
- Package connect4_pkg holds:
  - cell_t codes: EMPTY, FPGA, ARDUINO.
  - state_t enum.
  - direction row/column offset constants.
- Sub-module turn_timer holds the cycle counter, seconds counter, tick, and the expired/clear/enable interface. It is parametrised by CLK_HZ and TURN_SECS.
- The engine holds the board register array, heights array, FSM, and the combinational line-count function for one direction.

## Test plan
- Set CLK_HZ=10. After reset with first_player=1: cur_player=1 and secs_left=10. Drop into column 3 → cell (0,3)=10, cur_player=0 after 5 cycles post-edge.
- Fill column 0 with 6 drops, then a 7th drop → reject pulse, board unchanged, cur_player unchanged.
- Drop with column=7 (COLS=7) → reject. Hold load high for 20 cycles → exactly one drop.
- FPGA plays columns 0,1,2,3 while Arduino plays 0,1,2 in between → after FPGA's 4th drop: winner=01 in CHECK0 (edge t+1), game_over=1, later loads ignored.
- Repeat the win for vertical, diagonal and anti-diagonal lines. A 3-in-line plus an opponent token → no win.
- With CLK_HZ=10 and no load: timeout pulse after 100 WAIT cycles, player toggled, secs_left=10.
- Fill the board in a no-win order → draw=1, winner=00.
- Assert rst during CHECK2 → full reset state on the next cycle.

Source files
------------

// File: rtl/connect4_pkg.sv
// Shared types and constants for the Connect-4 engine.
//   cell_t  : two-bit cell codes stored on the board
//   state_t : engine FSM states
//   DIRn_DR / DIRn_DC : row/column step for each of the four line directions
//   dir_dr / dir_dc   : select the step for a direction index 0..3
package connect4_pkg;

  typedef enum logic [1:0] {
    EMPTY   = 2'b00,
    FPGA    = 2'b01,
    ARDUINO = 2'b10
  } cell_t;

  typedef enum logic [2:0] {
    S_WAIT   = 3'd0,
    S_CHECK0 = 3'd1,
    S_CHECK1 = 3'd2,
    S_CHECK2 = 3'd3,
    S_CHECK3 = 3'd4,
    S_OVER   = 3'd5
  } state_t;

  // d0 horizontal, d1 vertical, d2 diagonal, d3 anti-diagonal
  localparam int DIR0_DR = 0;
  localparam int DIR0_DC = 1;
  localparam int DIR1_DR = 1;
  localparam int DIR1_DC = 0;
  localparam int DIR2_DR = 1;
  localparam int DIR2_DC = 1;
  localparam int DIR3_DR = 1;
  localparam int DIR3_DC = -1;

  function automatic int dir_dr(input logic [1:0] d);
    case (d)
      2'd0:    dir_dr = DIR0_DR;
      2'd1:    dir_dr = DIR1_DR;
      2'd2:    dir_dr = DIR2_DR;
      default: dir_dr = DIR3_DR;
    endcase
  endfunction

  function automatic int dir_dc(input logic [1:0] d);
    case (d)
      2'd0:    dir_dc = DIR0_DC;
      2'd1:    dir_dc = DIR1_DC;
      2'd2:    dir_dc = DIR2_DC;
      default: dir_dc = DIR3_DC;
    endcase
  endfunction

endpackage

// File: rtl/connect4_engine_turn_timer.sv
// Per-turn timer: a cycle counter producing a one-second tick and a seconds
// counter. Counts only while enable is high, otherwise holds its value.
//   clk, rst   : clock, synchronous active-high reset
//   enable     : count this cycle
//   clear      : restart the turn (cycle and seconds counters to zero)
//   expired    : high on the cycle whose tick completes TURN_SECS seconds
//   secs_left  : TURN_SECS minus elapsed seconds
module turn_timer #(
  parameter int CLK_HZ    = 50_000_000,
  parameter int TURN_SECS = 10
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             enable,
  input  logic                             clear,
  output logic                             expired,
  output logic [$clog2(TURN_SECS+1)-1:0]   secs_left
);

  localparam int CYC_W = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam int SEC_W = $clog2(TURN_SECS + 1);

  logic [CYC_W-1:0] cyc_reg;
  logic [SEC_W-1:0] sec_reg;
  logic             tick;

  assign tick      = (cyc_reg == CYC_W'(CLK_HZ - 1));
  assign expired   = enable && tick && (sec_reg == SEC_W'(TURN_SECS - 1));
  assign secs_left = SEC_W'(TURN_SECS) - sec_reg;

  // Expiry restarts the count by itself so the seconds counter never
  // exceeds TURN_SECS even if the owner forgets to clear.
  always_ff @(posedge clk) begin
    if (rst || clear || expired) begin
      cyc_reg <= '0;
      sec_reg <= '0;
    end else if (enable) begin
      if (tick) begin
        cyc_reg <= '0;
        sec_reg <= sec_reg + 1'b1;
      end else begin
        cyc_reg <= cyc_reg + 1'b1;
      end
    end
  end

endmodule

// File: rtl/connect4_engine.sv
// Connect-4 game engine for a ROWS x COLS board.
// Holds the board and column heights, drops tokens under gravity on a load
// rising edge, checks the four line directions through the placed token one
// per cycle, alternates players, forfeits turns on timeout and flags win/draw.
//   clk, rst      : clock, synchronous active-high reset
//   column        : target column, 0 = leftmost
//   load          : move request, rising edge only
//   first_player  : starting player (0 FPGA, 1 Arduino), sampled in reset
//   board         : cell (r,c) at [2*(r*COLS+c) +: 2], row 0 = bottom
//   cur_player    : player to move
//   secs_left     : seconds left in the current turn
//   reject        : one-cycle pulse, move refused
//   timeout       : one-cycle pulse, turn forfeited
//   game_over     : level, game finished
//   winner        : 00 none/draw, 01 FPGA, 10 Arduino
//   draw          : board full with no winner
module connect4_engine
  import connect4_pkg::*;
#(
  parameter int ROWS      = 6,
  parameter int COLS      = 7,
  parameter int WIN_LEN   = 4,
  parameter int CLK_HZ    = 50_000_000,
  parameter int TURN_SECS = 10
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [$clog2(COLS)-1:0]         column,
  input  logic                            load,
  input  logic                            first_player,
  output logic [2*ROWS*COLS-1:0]          board,
  output logic                            cur_player,
  output logic [$clog2(TURN_SECS+1)-1:0]  secs_left,
  output logic                            reject,
  output logic                            timeout,
  output logic                            game_over,
  output logic [1:0]                      winner,
  output logic                            draw
);

  localparam int NCELL = ROWS * COLS;
  localparam int COL_W = $clog2(COLS);
  localparam int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int HGT_W = $clog2(ROWS + 1);
  localparam int IDX_W = $clog2(NCELL);
  localparam int MC_W  = $clog2(NCELL + 1);

  state_t            state_reg, state_next;
  logic [1:0]        cells_reg [NCELL];
  // Sized to the full column index range so an out-of-range column still
  // reads a defined (zero, never written) entry.
  logic [HGT_W-1:0]  heights_reg [1 << COL_W];
  logic [MC_W-1:0]   move_count_reg;
  logic [ROW_W-1:0]  place_row_reg;
  logic [COL_W-1:0]  place_col_reg;
  logic              cur_player_reg;
  logic              load_reg;
  logic              reject_reg, timeout_reg, draw_reg;
  logic [1:0]        winner_reg;

  logic              load_edge;
  logic [1:0]        token;
  logic [HGT_W-1:0]  col_height;
  logic              col_ok, col_full;
  logic [IDX_W-1:0]  wr_idx;
  logic              accept, reject_next, timeout_next, toggle, timer_clear;
  logic              win_set, draw_set;
  logic              timer_expired;

  // line-count scratch
  logic [1:0]        chk_dir;
  int                lc_dr, lc_dc, lc_r, lc_c, lc_count;
  logic              lc_run;
  logic              line_win;

  assign load_edge  = load && !load_reg;
  assign token      = {cur_player_reg, ~cur_player_reg};
  assign col_height = heights_reg[column];
  assign col_ok     = int'(column) < COLS;
  assign col_full   = int'(col_height) >= ROWS;
  assign wr_idx     = IDX_W'(int'(col_height) * COLS + int'(column));

  turn_timer #(
    .CLK_HZ    (CLK_HZ),
    .TURN_SECS (TURN_SECS)
  ) u_timer (
    .clk       (clk),
    .rst       (rst),
    .enable    (state_reg == S_WAIT),
    .clear     (timer_clear),
    .expired   (timer_expired),
    .secs_left (secs_left)
  );

  // Count of same-colour tokens on the line through the placed cell for the
  // direction being checked this cycle; each side stops at the first
  // mismatch or board edge and never looks further than WIN_LEN-1 cells.
  always_comb begin
    chk_dir = 2'd0;
    case (state_reg)
      S_CHECK1: chk_dir = 2'd1;
      S_CHECK2: chk_dir = 2'd2;
      S_CHECK3: chk_dir = 2'd3;
      default:  chk_dir = 2'd0;
    endcase
    lc_dr    = dir_dr(chk_dir);
    lc_dc    = dir_dc(chk_dir);
    lc_count = 1;
    lc_r     = 0;
    lc_c     = 0;
    lc_run   = 1'b0;
    for (int side = 0; side < 2; side++) begin
      lc_run = 1'b1;
      for (int k = 1; k < WIN_LEN; k++) begin
        lc_r = int'(place_row_reg) + ((side == 0) ? k : -k) * lc_dr;
        lc_c = int'(place_col_reg) + ((side == 0) ? k : -k) * lc_dc;
        if (lc_run && lc_r >= 0 && lc_r < ROWS && lc_c >= 0 && lc_c < COLS &&
            cells_reg[IDX_W'(lc_r * COLS + lc_c)] == token) begin
          lc_count = lc_count + 1;
        end else begin
          lc_run = 1'b0;
        end
      end
    end
    line_win = lc_count >= WIN_LEN;
  end

  // Next-state and per-cycle decisions
  always_comb begin
    state_next   = state_reg;
    accept       = 1'b0;
    reject_next  = 1'b0;
    timeout_next = 1'b0;
    toggle       = 1'b0;
    timer_clear  = 1'b0;
    win_set      = 1'b0;
    draw_set     = 1'b0;
    case (state_reg)
      S_WAIT: begin
        // Timeout takes precedence; a coincident load edge is dropped.
        if (timer_expired) begin
          timeout_next = 1'b1;
          toggle       = 1'b1;
          timer_clear  = 1'b1;
        end else if (load_edge) begin
          if (col_ok && !col_full) begin
            accept     = 1'b1;
            state_next = S_CHECK0;
          end else begin
            reject_next = 1'b1;
          end
        end
      end
      S_CHECK0, S_CHECK1, S_CHECK2: begin
        if (line_win) begin
          win_set    = 1'b1;
          state_next = S_OVER;
        end else begin
          state_next = state_t'(state_reg + 3'd1);
        end
      end
      S_CHECK3: begin
        if (line_win) begin
          win_set    = 1'b1;
          state_next = S_OVER;
        end else if (move_count_reg == MC_W'(NCELL)) begin
          draw_set   = 1'b1;
          state_next = S_OVER;
        end else begin
          toggle      = 1'b1;
          timer_clear = 1'b1;
          state_next  = S_WAIT;
        end
      end
      S_OVER:  state_next = S_OVER;
      default: state_next = S_WAIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= S_WAIT;
    end else begin
      state_reg <= state_next;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NCELL; i++) begin
        cells_reg[i] <= EMPTY;
      end
      for (int i = 0; i < (1 << COL_W); i++) begin
        heights_reg[i] <= '0;
      end
      move_count_reg <= '0;
      place_row_reg  <= '0;
      place_col_reg  <= '0;
    end else if (accept) begin
      cells_reg[wr_idx]   <= token;
      heights_reg[column] <= col_height + 1'b1;
      move_count_reg      <= move_count_reg + 1'b1;
      place_row_reg       <= ROW_W'(col_height);
      place_col_reg       <= column;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cur_player_reg <= first_player;
      load_reg       <= 1'b0;
      reject_reg     <= 1'b0;
      timeout_reg    <= 1'b0;
      winner_reg     <= EMPTY;
      draw_reg       <= 1'b0;
    end else begin
      load_reg    <= load;
      reject_reg  <= reject_next;
      timeout_reg <= timeout_next;
      if (toggle) begin
        cur_player_reg <= ~cur_player_reg;
      end
      if (win_set) begin
        winner_reg <= token;
      end
      if (draw_set) begin
        draw_reg <= 1'b1;
      end
    end
  end

  for (genvar gi = 0; gi < NCELL; gi++) begin : g_board
    assign board[2*gi +: 2] = cells_reg[gi];
  end

  assign cur_player = cur_player_reg;
  assign reject     = reject_reg;
  assign timeout    = timeout_reg;
  assign game_over  = (state_reg == S_OVER);
  assign winner     = winner_reg;
  assign draw       = draw_reg;

endmodule
